// File: rtl/sccb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_responder
//  Description : SCCB/I2C target emulating the OV7670 register bank. It
//                answers 3-phase writes, 2-phase pointer writes and reads on
//                an open-drain SCL/SDA pair and strobes every committed write.
//  Revision    : 1.0 - initial release
// ============================================================================
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR       = 7'h21,
  parameter int         FILTER_LEN     = 3,
  parameter bit         RESET_DEFAULTS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  localparam int         CNT_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [7:0] ADDR_COM7 = 8'h12;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_SUB      = 4'd3,
    ST_SUB_ACK  = 4'd4,
    ST_WR       = 4'd5,
    ST_WR_ACK   = 4'd6,
    ST_RD       = 4'd7,
    ST_RD_ACK   = 4'd8,
    ST_RD_NEXT  = 4'd9
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through the conditioning chain
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       filt_q;
  logic [1:0]       prev_q;
  logic [CNT_W-1:0] cnt_q [2];

  state_t     state_q;
  logic [7:0] sh_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       ack_on_q;
  logic       sda_oe_q;
  logic       busy_q;
  logic       wr_en_q;
  logic [7:0] wr_addr_q;
  logic [7:0] wr_data_q;
  logic [7:0] regs_q [256];

  logic       scl_rise;
  logic       scl_fall;
  logic       bus_start;
  logic       bus_stop;
  logic [7:0] rx_byte;
  logic [7:0] rd_cur;
  logic [7:0] rd_next;
  logic       soft_rst;

  function automatic logic [7:0] default_val(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (RESET_DEFAULTS) begin
      case (a)
        8'h0A:   v = 8'h76;
        8'h0B:   v = 8'h73;
        8'h1C:   v = 8'h7F;
        8'h1D:   v = 8'hA2;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  function automatic logic is_ro(input logic [7:0] a);
    return (a == 8'h0A) || (a == 8'h0B) || (a == 8'h1C) || (a == 8'h1D);
  endfunction

  // Synchronise both pads; a filtered level only follows after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {sda_i, scl_i};
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
          filt_q[i] <= sync2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign scl_rise  = filt_q[0] & ~prev_q[0];
  assign scl_fall  = ~filt_q[0] & prev_q[0];
  assign bus_start = filt_q[0] & prev_q[0] & prev_q[1] & ~filt_q[1];
  assign bus_stop  = filt_q[0] & prev_q[0] & ~prev_q[1] & filt_q[1];
  assign rx_byte   = {sh_q[6:0], filt_q[1]};
  assign rd_cur    = regs_q[ptr_q];
  assign rd_next   = regs_q[ptr_q + 8'd1];

  // Protocol engine: bus conditions first (STOP wins), then per-state bit handling
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= 8'h00;
      bit_cnt_q <= 4'd0;
      ptr_q     <= 8'h00;
      rw_q      <= 1'b0;
      ack_on_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      if (bus_stop) begin
        state_q   <= ST_IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= 4'd0;
        ack_on_q  <= 1'b0;
      end else if (bus_start) begin
        state_q   <= ST_ADDR;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= 4'd0;
        ack_on_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            sda_oe_q <= 1'b0;
          end
          ST_ADDR, ST_SUB, ST_WR: begin
            if (scl_rise) begin
              sh_q      <= rx_byte;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                bit_cnt_q <= 4'd0;
                if (state_q == ST_ADDR) begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state_q <= ST_ADDR_ACK;
                    busy_q  <= 1'b1;
                    rw_q    <= rx_byte[0];
                  end else begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                  end
                end else if (state_q == ST_SUB) begin
                  ptr_q   <= rx_byte;
                  state_q <= ST_SUB_ACK;
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= ptr_q;
                  wr_data_q <= rx_byte;
                  ptr_q     <= ptr_q + 8'd1;
                  state_q   <= ST_WR_ACK;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_SUB_ACK, ST_WR_ACK: begin
            // First fall after the 8th bit pulls SDA, the following fall releases it
            if (scl_fall) begin
              if (!ack_on_q) begin
                sda_oe_q <= 1'b1;
                ack_on_q <= 1'b1;
              end else begin
                ack_on_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
                if (state_q == ST_ADDR_ACK && rw_q) begin
                  sh_q     <= rd_cur;
                  sda_oe_q <= ~rd_cur[7];
                  state_q  <= ST_RD;
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == ST_ADDR_ACK) ? ST_SUB : ST_WR;
                end
              end
            end
          end
          ST_RD: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                sda_oe_q <= ~sh_q[~bit_cnt_q[2:0]];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!filt_q[1]) begin
                ptr_q   <= ptr_q + 8'd1;
                sh_q    <= rd_next;
                state_q <= ST_RD_NEXT;
              end else begin
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
                state_q  <= ST_IDLE;
              end
            end
          end
          ST_RD_NEXT: begin
            if (scl_fall) begin
              sda_oe_q  <= ~sh_q[7];
              bit_cnt_q <= 4'd0;
              state_q   <= ST_RD;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign soft_rst = wr_en_q && (wr_addr_q == ADDR_COM7) && wr_data_q[7];

  // Register bank: applies strobed writes, ignores read-only IDs, COM7[7] reloads defaults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= default_val(8'(i));
    end else if (soft_rst) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= default_val(8'(i));
    end else if (wr_en_q && !is_ro(wr_addr_q)) begin
      regs_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_responder
//  Description : Bus-level initiator model driving sccb_responder with write,
//                read, burst, mismatch, read-only, soft-reset, glitch and
//                async-reset scenarios. Write strobes and read bytes are
//                checked against queues of expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_responder;

  localparam int QCLK = 10;  // clk cycles per quarter SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       reg_wr_en;
  logic [7:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] sb_wr[$];
  logic [7:0]  sb_rd[$];
  logic        oe_seen;
  logic        busy_seen;

  assign sda_line = sda_m & ~sda_oe;

  sccb_responder #(
    .DEV_ADDR      (7'h21),
    .FILTER_LEN    (3),
    .RESET_DEFAULTS(1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_oe     (sda_oe),
    .reg_wr_en  (reg_wr_en),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every strobe must match the oldest pending expected write
  always @(negedge clk) begin
    if (reset === 1'b0 && reg_wr_en === 1'b1) begin
      check("wr_strobe_expected", 32'(sb_wr.size() != 0), 32'd1);
      if (sb_wr.size() != 0) check("wr_strobe", {reg_wr_addr, reg_wr_data}, sb_wr.pop_front());
    end
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic q_wait();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic bus_start();
    if (scl_m == 1'b0) begin
      q_wait(); sda_m = 1'b1;
      q_wait(); scl_m = 1'b1;
      q_wait();
    end
    sda_m = 1'b0;
    q_wait(); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    q_wait(); sda_m = 1'b0;
    q_wait(); scl_m = 1'b1;
    q_wait(); sda_m = 1'b1;
    q_wait(); q_wait();
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    q_wait(); sda_m = b;
    if (glitch) begin
      @(negedge clk); scl_m = 1'b1;
      @(negedge clk); scl_m = 1'b0;
    end
    q_wait(); scl_m = 1'b1;
    q_wait(); q_wait(); scl_m = 1'b0;
  endtask

  // exp_line: level the initiator should see in the 9th slot (0 = ACK)
  task automatic write_byte(input logic [7:0] b, input logic exp_line, input int glitch_bit);
    logic line;
    for (int i = 7; i >= 0; i--) send_bit(b[i], i == glitch_bit);
    q_wait(); sda_m = 1'b1;
    q_wait(); scl_m = 1'b1;
    q_wait();
    line = sda_line;
    check("ack_line", 32'(line), 32'(exp_line));
    if (!exp_line) check("ack_oe", 32'(sda_oe), 32'd1);
    q_wait(); scl_m = 1'b0;
  endtask

  // ack = 1 drives ACK in the 9th slot, 0 leaves NACK
  task automatic read_byte(input logic ack, output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      q_wait(); sda_m = 1'b1;
      q_wait(); scl_m = 1'b1;
      q_wait(); b[i] = sda_line;
      q_wait(); scl_m = 1'b0;
    end
    q_wait(); sda_m = ack ? 1'b0 : 1'b1;
    q_wait(); scl_m = 1'b1;
    q_wait(); q_wait(); scl_m = 1'b0;
  endtask

  task automatic read_cmp(input logic ack);
    logic [7:0] d;
    read_byte(ack, d);
    check("rd_expected", 32'(sb_rd.size() != 0), 32'd1);
    if (sb_rd.size() != 0) check("rd_data", 32'(d), 32'(sb_rd.pop_front()));
  endtask

  task automatic do_write(input logic [7:0] sub, input logic [7:0] data, input int glitch_bit);
    bus_start();
    write_byte(8'h42, 1'b0, -1);
    write_byte(sub, 1'b0, -1);
    sb_wr.push_back({sub, data});
    write_byte(data, 1'b0, glitch_bit);
    bus_stop();
  endtask

  task automatic do_read(input logic [7:0] sub, input logic [7:0] exp);
    bus_start();
    write_byte(8'h42, 1'b0, -1);
    write_byte(sub, 1'b0, -1);
    bus_stop();
    bus_start();
    write_byte(8'h43, 1'b0, -1);
    sb_rd.push_back(exp);
    read_cmp(1'b0);
    q_wait();
    check("rd_release", 32'(sda_oe), 32'd0);
    bus_stop();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_wr_en", 32'(reg_wr_en), 32'd0);
    check("rst_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // 3-phase write
    bus_start();
    write_byte(8'h42, 1'b0, -1);
    check("busy_after_addr", 32'(busy), 32'd1);
    write_byte(8'h12, 1'b0, -1);
    sb_wr.push_back(16'h1204);
    write_byte(8'h04, 1'b0, -1);
    bus_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("wr_pending_t1", 32'(sb_wr.size()), 32'd0);

    // 2-phase write then read of an ID register
    do_read(8'h0A, 8'h76);

    // Burst write across the pointer wrap, then burst read back
    bus_start();
    write_byte(8'h42, 1'b0, -1);
    write_byte(8'hFE, 1'b0, -1);
    sb_wr.push_back(16'hFE11);
    write_byte(8'h11, 1'b0, -1);
    sb_wr.push_back(16'hFF22);
    write_byte(8'h22, 1'b0, -1);
    sb_wr.push_back(16'h0033);
    write_byte(8'h33, 1'b0, -1);
    bus_stop();
    check("wr_pending_t3", 32'(sb_wr.size()), 32'd0);
    bus_start();
    write_byte(8'h42, 1'b0, -1);
    write_byte(8'hFE, 1'b0, -1);
    bus_stop();
    bus_start();
    write_byte(8'h43, 1'b0, -1);
    sb_rd.push_back(8'h11);
    read_cmp(1'b1);
    sb_rd.push_back(8'h22);
    read_cmp(1'b0);
    q_wait();
    check("burst_rd_release", 32'(sda_oe), 32'd0);
    bus_stop();

    // Foreign address: never ACKed, never busy, no strobe
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    bus_start();
    write_byte(8'h44, 1'b1, -1);
    write_byte(8'h12, 1'b1, -1);
    bus_stop();
    check("mismatch_oe_seen", 32'(oe_seen), 32'd0);
    check("mismatch_busy_seen", 32'(busy_seen), 32'd0);
    // Pointer set then repeated START into a read
    bus_start();
    write_byte(8'h42, 1'b0, -1);
    write_byte(8'h0B, 1'b0, -1);
    bus_start();
    write_byte(8'h43, 1'b0, -1);
    sb_rd.push_back(8'h73);
    read_cmp(1'b0);
    bus_stop();

    // Read-only register and COM7 soft reset
    do_write(8'h1C, 8'h55, -1);
    do_read(8'h1C, 8'h7F);
    do_write(8'h12, 8'h80, -1);
    do_read(8'h12, 8'h00);
    do_read(8'h00, 8'h00);
    do_read(8'h0A, 8'h76);
    do_read(8'h1D, 8'hA2);

    // One-clk SCL glitch inside a data byte must not add a bit
    do_write(8'h20, 8'h05, 3);
    do_read(8'h20, 8'h05);

    // Reset while the responder holds the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'h42 >> i) & 8'h01) != 8'h00, 1'b0);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rst_ack_driven", 32'(sda_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_async_oe", 32'(sda_oe), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    do_read(8'h0B, 8'h73);
    do_read(8'h20, 8'h00);
    do_write(8'h30, 8'hA5, -1);
    do_read(8'h30, 8'hA5);

    repeat (20) @(negedge clk);
    check("wr_pending_end", 32'(sb_wr.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
